vote_collector: RTL and testbench

Front-end stage for the 3-input majority voter. It synchronises and debounces four raw board keys (one start key and three voter keys) and runs a timed voting session. It latches each voter's yes-vote and presents the three votes as stable registered levels a, b, c that feed the voter's a/b/c inputs directly. Session status is brought out for the board LEDs.

---
 rtl/vote_collector.sv | 137 +++++++++++++
 tb/tb_vote_collector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_collector.sv
// Voting-session front end: synchronises and debounces the start key and three
// voter keys, runs a timed window and latches each voter's yes-vote as a/b/c.
module vote_collector #(
  parameter int DEB_CYCLES    = 240000,
  parameter int WINDOW_CYCLES = 60000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic [2:0] key_vote_n,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       open,
  output logic       done,
  output logic [1:0] vote_cnt
);
  localparam int NKEYS = 4;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [WW-1:0] WIN_MAX = WW'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_RESULT} state_t;

  logic [NKEYS-1:0] w_keys_n;
  logic [NKEYS-1:0] w_press;
  logic             w_start;
  logic [2:0]       w_vpress;

  assign w_keys_n = {key_vote_n, key_start_n};
  assign w_start  = w_press[0];
  assign w_vpress = w_press[3:1];

  // Per-key lane: 2-FF synchroniser, debounce counter, registered press pulse.
  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_deb_d;
    logic          r_press;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_deb   <= 1'b1;
        r_deb_d <= 1'b1;
        r_press <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_keys_n[k];
        r_sync2 <= r_sync1;
        r_deb_d <= r_deb;
        // Falling edge of the debounced level only; releases are silent.
        r_press <= r_deb_d & ~r_deb;
        if (r_sync2 == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == DEB_MAX) begin
          r_deb <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end
    end

    assign w_press[k] = r_press;
  end

  function automatic logic [1:0] pop3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  state_t          r_state;
  logic [WW-1:0]   r_win;
  logic [2:0]      r_votes;
  logic [1:0]      r_cnt;
  logic            r_open;
  logic            r_done;

  state_t          w_state_nxt;
  logic [WW-1:0]   w_win_nxt;
  logic [2:0]      w_votes_nxt;
  logic [1:0]      w_cnt_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_votes_nxt = r_votes;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_RESULT: begin
        if (w_start) begin
          w_state_nxt = S_OPEN;
          w_win_nxt   = WIN_MAX;
          w_votes_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_OPEN: begin
        // A press in the last window cycle still lands before closing.
        w_votes_nxt = r_votes | w_vpress;
        w_cnt_nxt   = pop3(r_votes | w_vpress);
        if (r_win != '0) w_win_nxt = r_win - WW'(1);
        if (r_win == '0 || r_cnt == 2'd3) w_state_nxt = S_RESULT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_votes <= '0;
      r_cnt   <= '0;
      r_open  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_votes <= w_votes_nxt;
      r_cnt   <= w_cnt_nxt;
      r_open  <= (w_state_nxt == S_OPEN);
      r_done  <= (w_state_nxt == S_RESULT);
    end
  end

  assign a        = r_votes[0];
  assign b        = r_votes[1];
  assign c        = r_votes[2];
  assign vote_cnt = r_cnt;
  assign open     = r_open;
  assign done     = r_done;
endmodule

// File: tb/tb_vote_collector.sv
// Directed session scenarios plus random key activity, checked against a
// cycle-level behavioural model of key filtering and voting sessions.
module tb_vote_collector;
  localparam int DEB = 4;
  localparam int WIN = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_n = 1'b1;
  logic [2:0] vote_n = 3'b111;
  logic       a, b, c, open, done;
  logic [1:0] vote_cnt;

  int ncmp = 0;
  int nerr = 0;

  vote_collector #(.DEB_CYCLES(DEB), .WINDOW_CYCLES(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .key_start_n(start_n), .key_vote_n(vote_n),
    .a(a), .b(b), .c(c), .open(open), .done(done), .vote_cnt(vote_cnt)
  );

  always #5 clk = ~clk;

  // Reference model. Key k (0=start, 1..3=voters) is accepted at a new level
  // once the level seen through two sync stages has differed from the accepted
  // level for DEB consecutive clocks; a press reaches the session logic two
  // clocks after acceptance.
  bit        hist [4][DEB+2];
  bit        dlev [4] = '{1, 1, 1, 1};
  bit        flp  [4] = '{0, 0, 0, 0};
  bit        pq   [4] = '{0, 0, 0, 0};
  int        mode = 0;        // 0 idle, 1 open, 2 result
  int        left = 0;        // window cycles still to run
  bit  [2:0] mv   = 3'b000;
  int        mcnt = 0;
  int        prev_cnt;
  bit        all_diff;

  initial begin
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < DEB + 2; j++) hist[k][j] = 1'b1;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        for (int j = 0; j < DEB + 2; j++) hist[k][j] = 1'b1;
        dlev[k] = 1'b1; flp[k] = 1'b0; pq[k] = 1'b0;
      end
      mode = 0; left = 0; mv = 3'b000; mcnt = 0;
    end else begin
      if (mode == 1) begin
        prev_cnt = mcnt;
        mv = mv | {pq[3], pq[2], pq[1]};
        mcnt = $countones(mv);
        left = left - 1;
        if (left == 0 || prev_cnt == 3) mode = 2;
      end else if (pq[0]) begin
        mode = 1; left = WIN; mv = 3'b000; mcnt = 0;
      end
      for (int k = 0; k < 4; k++) begin
        pq[k] = flp[k];
        for (int j = DEB + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = (k == 0) ? start_n : vote_n[k-1];
        all_diff = 1'b1;
        for (int j = 2; j < DEB + 2; j++)
          if (hist[k][j] == dlev[k]) all_diff = 1'b0;
        flp[k] = 1'b0;
        if (all_diff) begin
          dlev[k] = ~dlev[k];
          flp[k] = (dlev[k] == 1'b0);
        end
      end
    end
  end

  // Length of the most recent completed open window.
  int open_len = 0;
  int last_len = 0;
  always @(negedge clk) begin
    if (open) open_len++;
    else if (open_len != 0) begin last_len = open_len; open_len = 0; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a", a, mv[0]);
    chk("b", b, mv[1]);
    chk("c", c, mv[2]);
    chk("open", open, mode == 1);
    chk("done", done, mode == 2);
    chk("vote_cnt", vote_cnt, mcnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic start_session(input string tag);
    start_n = 1'b0;
    for (int i = 0; i < 20 && !open; i++) tick();
    chk(tag, open, 1);
    start_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_abc", {a, b, c}, 0);
    chk("rst_open", open, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", vote_cnt, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: start key -> open exactly 8 clocks after key low
    start_n = 1'b0;
    repeat (7) tick();
    chk("open_at_7", open, 0);
    tick();
    chk("open_at_8", open, 1);
    chk("s1_abc", {a, b, c}, 0);
    chk("s1_cnt", vote_cnt, 0);
    chk("s1_done", done, 0);
    repeat (2) tick();
    start_n = 1'b1;

    // 2: keys 0 and 2 with bounce, window times out after 50 cycles
    vote_n = 3'b010; tick();
    vote_n = 3'b111; tick();
    vote_n = 3'b010; tick();
    vote_n = 3'b111; tick();
    vote_n = 3'b010;
    repeat (12) tick();
    chk("s2_abc", {a, b, c}, 3'b101);
    chk("s2_cnt", vote_cnt, 2);
    chk("s2_open", open, 1);
    for (int i = 0; i < 80 && !done; i++) tick();
    chk("s2_done", done, 1);
    chk("s2_closed", open, 0);
    chk("s2_hold", {a, b, c}, 3'b101);
    tick();
    chk("s2_len", last_len, WIN);
    vote_n = 3'b111;
    repeat (10) tick();

    // 3: all three at once -> count 3 in one step, close next cycle
    start_session("s3_open");
    vote_n = 3'b000;
    for (int i = 0; i < 20 && vote_cnt == 2'd0; i++) tick();
    chk("s3_cnt", vote_cnt, 3);
    chk("s3_abc", {a, b, c}, 3'b111);
    chk("s3_not_done", done, 0);
    tick();
    chk("s3_done", done, 1);
    chk("s3_closed", open, 0);
    tick();
    chk("s3_early", last_len < WIN, 1);
    vote_n = 3'b111;
    repeat (10) tick();

    // 4: glitches on key 1 ignored, double press latched once
    start_session("s4_open");
    vote_n[1] = 1'b0; repeat (2) tick();
    vote_n[1] = 1'b1; repeat (5) tick();
    vote_n[1] = 1'b0; repeat (3) tick();
    vote_n[1] = 1'b1; repeat (6) tick();
    chk("s4_glitch_b", b, 0);
    chk("s4_glitch_cnt", vote_cnt, 0);
    vote_n[1] = 1'b0; repeat (8) tick();
    vote_n[1] = 1'b1; repeat (8) tick();
    vote_n[1] = 1'b0; repeat (8) tick();
    vote_n[1] = 1'b1;
    chk("s4_abc", {a, b, c}, 3'b010);
    chk("s4_cnt", vote_cnt, 1);
    chk("s4_open", open, 1);
    for (int i = 0; i < 60 && !done; i++) tick();
    chk("s4_done", done, 1);

    // 5: voter press consumed in the final window cycle, then restart
    start_session("s5_open");
    repeat (42) tick();
    vote_n[0] = 1'b0;
    repeat (7) tick();
    chk("s5_pre_open", open, 1);
    chk("s5_pre_a", a, 0);
    tick();
    chk("s5_done", done, 1);
    chk("s5_a", a, 1);
    chk("s5_cnt", vote_cnt, 1);
    repeat (4) tick();
    vote_n[0] = 1'b1;
    repeat (8) tick();
    start_session("s5_reopen");
    chk("s5_new_abc", {a, b, c}, 0);
    chk("s5_new_cnt", vote_cnt, 0);
    chk("s5_new_done", done, 0);

    // 6: reset mid-session discards votes; voters ignored until start
    vote_n = 3'b100;
    for (int i = 0; i < 20 && vote_cnt != 2'd2; i++) tick();
    chk("s6_cnt", vote_cnt, 2);
    vote_n = 3'b111;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s6_rst_abc", {a, b, c}, 0);
    chk("s6_rst_cnt", vote_cnt, 0);
    chk("s6_rst_open", open, 0);
    chk("s6_rst_done", done, 0);
    repeat (10) tick();
    vote_n[2] = 1'b0; repeat (10) tick();
    vote_n[2] = 1'b1; repeat (10) tick();
    chk("s6_idle_c", c, 0);
    chk("s6_idle_open", open, 0);
    start_session("s6_open");

    // Random key activity with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) start_n = ~start_n;
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 14) == 0) vote_n[k] = ~vote_n[k];
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1;
    start_n = 1'b1;
    vote_n = 3'b111;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
